// File: rtl/eth_param_fifo.sv
// -----------------------------------------------------------------------------
// eth_param_fifo
//   Single-clock parameterised FIFO with status flags and error pulses.
//
//   Build option: define ETH_FIFO_FWFT_EN for first-word-fall-through mode.
//   Without it, Q is registered and updates one cycle after an accepted read.
//
// Parameters
//   WIDTH      data word width (1..64)
//   DEPTH      storage words, power of two (4..4096)
//   AF_THRESH  Almost_Full when Count >= AF_THRESH
//   AE_THRESH  Almost_Empty when Count <= AE_THRESH
//   AW         derived pointer index width, log2(DEPTH)
//
// Ports
//   Clk           clock, rising edge
//   Rst_n         asynchronous active-low reset
//   Wr_En         write request (dropped when Full)
//   Rd_En         read request / FWFT read acknowledge (rejected when Empty)
//   Data          write data
//   Q             read data
//   Empty, Full, Almost_Empty, Almost_Full   status flags
//   Count         words stored, 0..DEPTH
//   Overflow      one-cycle pulse after a dropped write
//   Underflow     one-cycle pulse after a read on an empty FIFO
//
// Handshake: a write is taken on a rising edge when Wr_En=1 and Full=0; a read
// is taken when Rd_En=1 and Empty=0. Both may be taken on the same edge.
// -----------------------------------------------------------------------------
module eth_param_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 512,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Wr_En,
    input  logic             Rd_En,
    input  logic [WIDTH-1:0] Data,
    output logic [WIDTH-1:0] Q,
    output logic             Empty,
    output logic             Full,
    output logic             Almost_Empty,
    output logic             Almost_Full,
    output logic [AW:0]      Count,
    output logic             Overflow,
    output logic             Underflow
);

    // Thresholds sized to the Count width so the flag compares are width-exact.
    localparam logic [AW:0] DEPTH_LVL = DEPTH[AW:0];
    localparam logic [AW:0] AF_LVL    = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_LVL    = AE_THRESH[AW:0];

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_overflow;
    logic             r_underflow;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [AW:0]      w_count;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic [AW-1:0]    w_rd_idx;
    logic [AW-1:0]    w_wr_idx;

    // Count and flags depend only on the registered pointers; the extra
    // pointer bit distinguishes full from empty.
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign Count        = w_count;
    assign Empty        = (w_count == '0);
    assign Full         = (w_count == DEPTH_LVL);
    assign Almost_Full  = (w_count >= AF_LVL);
    assign Almost_Empty = (w_count <= AE_LVL);
    assign Overflow     = r_overflow;
    assign Underflow    = r_underflow;

    assign w_wr_ok  = Wr_En & ~Full;
    assign w_rd_ok  = Rd_En & ~Empty;
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_wr_idx = r_wr_ptr[AW-1:0];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_overflow  <= Wr_En & Full;
            r_underflow <= Rd_En & Empty;
        end
    end

    // Storage is not reset; resetting the pointers makes old contents
    // unreachable. Writes are blocked while reset is held.
    always_ff @(posedge Clk) begin
        if (Rst_n && w_wr_ok) r_mem[w_wr_idx] <= Data;
    end

`ifdef ETH_FIFO_FWFT_EN
    // Head word is shown directly; forced to zero while empty so reset and
    // idle both present 0.
    assign Q = Empty ? '0 : r_mem[w_rd_idx];
`else
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_q <= '0;
        end else if (w_rd_ok) begin
            r_q <= r_mem[w_rd_idx];
        end
    end

    assign Q = r_q;
`endif

endmodule

// File: tb/tb_eth_param_fifo.sv
module tb_eth_param_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF_TH = 14;
  localparam int AE_TH = 2;
  localparam int AW    = 4;

  logic             Clk;
  logic             Rst_n;
  logic             Wr_En;
  logic             Rd_En;
  logic [WIDTH-1:0] Data;
  logic [WIDTH-1:0] Q;
  logic             Empty;
  logic             Full;
  logic             Almost_Empty;
  logic             Almost_Full;
  logic [AW:0]      Count;
  logic             Overflow;
  logic             Underflow;

  int err_cnt = 0;
  int chk_cnt = 0;

  // reference model: FIFO contents as a queue, plus the expected Q register
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_ovf;
  logic             exp_udf;

  eth_param_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AF_THRESH(AF_TH),
    .AE_THRESH(AE_TH)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Wr_En(Wr_En),
    .Rd_En(Rd_En),
    .Data(Data),
    .Q(Q),
    .Empty(Empty),
    .Full(Full),
    .Almost_Empty(Almost_Empty),
    .Almost_Full(Almost_Full),
    .Count(Count),
    .Overflow(Overflow),
    .Underflow(Underflow)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

  task automatic check_outputs(input string where);
    int sz;
    sz = exp_q.size();
    check_val({where, ":count"}, 32'(Count), 32'(sz));
    check_val({where, ":empty"}, 32'(Empty), 32'(sz == 0));
    check_val({where, ":full"},  32'(Full),  32'(sz == DEPTH));
    check_val({where, ":af"},    32'(Almost_Full),  32'(sz >= AF_TH));
    check_val({where, ":ae"},    32'(Almost_Empty), 32'(sz <= AE_TH));
    check_val({where, ":ovf"},   32'(Overflow),  32'(exp_ovf));
    check_val({where, ":udf"},   32'(Underflow), 32'(exp_udf));
`ifdef ETH_FIFO_FWFT_EN
    if (sz != 0) check_val({where, ":q"}, 32'(Q), 32'(exp_q[0]));
`else
    check_val({where, ":q"}, 32'(Q), 32'(exp_dout));
`endif
  endtask

  // driver: apply one cycle of stimulus, advance the model, compare
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input string where);
    logic was_full;
    logic was_empty;
    @(negedge Clk);
    Wr_En = w;
    Rd_En = r;
    Data  = d;
    @(posedge Clk);
    #1;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    exp_ovf = w && was_full;
    exp_udf = r && was_empty;
    if (r && !was_empty) exp_dout = exp_q.pop_front();
    if (w && !was_full) exp_q.push_back(d);
    check_outputs(where);
  endtask

  initial begin
    Rst_n = 1'b0;
    Wr_En = 1'b0;
    Rd_En = 1'b0;
    Data  = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge Clk);
    Rst_n = 1'b1;

    // fill to full with 0x01..0x10, then one dropped write
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), "fill");
    step(1'b1, 1'b0, 8'hAA, "overflow");
    step(1'b0, 1'b0, 8'h00, "ovf_clear");

    // drain in order, then a read on empty
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 8'h00, "drain");
    step(1'b0, 1'b1, 8'h00, "underflow");
    step(1'b0, 1'b0, 8'h00, "udf_clear");

    // simultaneous traffic at mid-level across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), "prefill");
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)), "stream");

    // random mix, biased toward each end in turn
    for (int i = 0; i < 300; i++) begin
      logic w;
      logic r;
      if ((i / 60) % 2 == 0) begin
        w = ($urandom_range(0, 99) < 70);
        r = ($urandom_range(0, 99) < 35);
      end else begin
        w = ($urandom_range(0, 99) < 35);
        r = ($urandom_range(0, 99) < 70);
      end
      step(w, r, 8'($urandom_range(0, 255)), "random");
    end

    // drain, then reset mid-cycle with 5 words stored
    while (exp_q.size() != 0) step(1'b0, 1'b1, 8'h00, "pre_rst_drain");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), "rst_fill");
    @(negedge Clk);
    Wr_En = 1'b1;
    Rd_En = 1'b1;
    Data  = 8'h77;
    #2;
    Rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge Clk);
    Wr_En = 1'b0;
    Rd_En = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, "post_rst");

    // single word: visibility on Q depends on build mode
    step(1'b1, 1'b0, 8'h5A, "w5a");
    step(1'b0, 1'b0, 8'h00, "w5a_idle");
    step(1'b0, 1'b1, 8'h00, "r5a");
    step(1'b0, 1'b0, 8'h00, "r5a_idle");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/eth_param_fifo.md
ETH_PARAM_FIFO -- requirements
Module: eth_param_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 512, storage words; power of two, 4..4096.
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-4, the Almost_Full level in words (1..DEPTH-1).
REQ-004 The block SHALL have parameter AE_THRESH, default 4, the Almost_Empty level in words (0..DEPTH-2).
REQ-005 The block SHALL derive localparam AW = log2(DEPTH); it SHALL have no other pointer-size parameter.
REQ-006 The block SHALL have Clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have Rst_n  input  1  reset; asynchronous assert, active-low.
REQ-008 The block SHALL have Wr_En  input  1  write request.
REQ-009 The block SHALL have Rd_En  input  1  read request (read acknowledge in FWFT mode).
REQ-010 The block SHALL have Data  input  WIDTH  write data.
REQ-011 The block SHALL have Q  output  WIDTH  read data.
REQ-012 The block SHALL have Empty, Full, Almost_Empty, Almost_Full  output  1 each  status flags.
REQ-013 The block SHALL have Count  output  AW+1  words stored (0..DEPTH).
REQ-014 The block SHALL have Overflow, Underflow  output  1 each  single-cycle error pulses.

Function
REQ-015 Write and read pointers SHALL be AW+1 bits and wrap modulo 2^(AW+1); memory SHALL be indexed by pointer bits [AW-1:0].
REQ-016 Count SHALL equal wr_ptr - rd_ptr (modulo 2^(AW+1)), updated on the same edge as the pointers.
REQ-017 Empty SHALL be 1 iff Count == 0; Full SHALL be 1 iff Count == DEPTH.
REQ-018 Almost_Full SHALL be 1 iff Count >= AF_THRESH; Almost_Empty SHALL be 1 iff Count <= AE_THRESH.
REQ-019 A write SHALL be accepted iff Wr_En == 1 and Full == 0: Data stored at wr_ptr, wr_ptr incremented.
REQ-020 A write with Full == 1 SHALL be dropped regardless of Rd_En; memory and wr_ptr unchanged.
REQ-021 A read SHALL be accepted iff Rd_En == 1 and Empty == 0; rd_ptr incremented.
REQ-022 Simultaneous accepted read and write SHALL leave Count unchanged.
REQ-023 A dropped write SHALL assert Overflow for exactly the cycle after the edge; a read with Empty == 1 SHALL assert Underflow for exactly the cycle after the edge.
REQ-024 A rejected read SHALL leave Q and rd_ptr unchanged.
REQ-025 Status flags and Count SHALL be decoded from registered pointers only; no combinational path from Wr_En/Rd_En/Data to any flag or Count.

Reset
REQ-026 While Rst_n == 0, pointers SHALL be 0, Q 0, Count 0, Empty 1, Almost_Empty 1, Full 0, Almost_Full 0, Overflow 0, Underflow 0, independent of Clk.
REQ-027 Memory contents SHALL NOT be reset; data present before reset SHALL be unreadable afterwards.
REQ-028 Reset asserted mid-transfer SHALL discard the in-flight write and read; the first edge after release with Rst_n == 1 SHALL behave as on an empty FIFO.

Configuration
REQ-029 Macro ETH_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
REQ-030 Without ETH_FIFO_FWFT_EN, Q SHALL be registered: on an accepted read, Q <= memory[rd_ptr] at that edge (one-cycle read latency); Q holds otherwise.
REQ-031 With ETH_FIFO_FWFT_EN, Q SHALL continuously present memory[rd_ptr] (valid iff Empty == 0); an accepted read advances to the next word, visible the cycle after the edge; a word written into an empty FIFO SHALL appear on Q, with Empty == 0, the cycle after its write edge.
REQ-032 Flag, Count, Overflow and Underflow behaviour SHALL be identical in both modes.

Verification (WIDTH=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2)
REQ-033 Write 0x01..0x10 (16 words) -> Full=1, Count=16, Almost_Full=1 from 14th write; 17th write 0xAA -> Overflow pulse 1 cycle, Count stays 16.
REQ-034 Read 16 words after fill -> Q sequence 0x01..0x10, Empty=1 after last; extra Rd_En -> Underflow pulse 1 cycle, Q holds 0x10.
REQ-035 Write/read 40 words at Count~8 with simultaneous Wr_En/Rd_En -> Count constant, data in order across pointer wrap.
REQ-036 Fill 5 words, drop Rst_n mid-cycle -> all outputs at reset values before next Clk edge; after release Empty=1, Count=0.
REQ-037 FWFT build: write 0x5A to empty FIFO -> Q=0x5A and Empty=0 one cycle later without Rd_En; Rd_En -> Empty=1 next cycle.
REQ-038 Standard build: same stimulus -> Q stays 0x00 until Rd_En; Q=0x5A the cycle after the read edge.
